// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: tag constants, idle bus value, default widths and the
// CDB arbiter state encoding.
package tomasulo_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned TAG_W_DEF  = 3;

  localparam logic [2:0] FREE_REGISTER    = 3'd0;
  localparam logic [2:0] RES_STATION_ADD1 = 3'd1;
  localparam logic [2:0] RES_STATION_ADD2 = 3'd2;

  // Value driven on the data bus when nothing is being broadcast.
  localparam logic [15:0] sem_valor = 16'hFFF0;

  typedef enum logic {
    StIdle,
    StBcast
  } cdb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set bit of elig_i at or above ptr_i, wrapping to
// the lowest set bit when nothing at or above the pointer is set.
module rr_picker #(
  parameter int unsigned N    = 2,
  parameter int unsigned PtrW = 1
) (
  input  logic [N-1:0]    elig_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [PtrW-1:0] idx_o,
  output logic            any_o
);

  logic [N-1:0]    mask;
  logic [N-1:0]    hi;
  logic            hi_any;
  logic [PtrW-1:0] hi_idx;
  logic [PtrW-1:0] lo_idx;

  always_comb begin
    mask   = '0;
    hi_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (PtrW'(i) >= ptr_i);
    end
    hi = elig_i & mask;
    // Descending scan so the lowest matching index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (hi[i]) begin
        hi_any = 1'b1;
        hi_idx = PtrW'(i);
      end
      if (elig_i[i]) begin
        lo_idx = PtrW'(i);
      end
    end
    any_o = |elig_i;
    idx_o = hi_any ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter: registers one station's tag/result per cycle and acks it.
// Optional statistics counters are built when CDB_STATS_EN is defined.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int unsigned N_ST   = 2,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [N_ST-1:0]        Ready,
  input  logic [N_ST*DATA_W-1:0] Result,
  input  logic                   Stall,
  output logic [N_ST-1:0]        Ack,
  output logic                   CDB_Valid,
  output logic [TAG_W-1:0]       Qi_CDB,
  output logic [DATA_W-1:0]      Qi_CDB_data
`ifdef CDB_STATS_EN
  ,
  output logic [15:0]            Bcast_Count,
  output logic [15:0]            Conflict_Count
`endif
);

  localparam int unsigned PtrW = $clog2(N_ST);

  cdb_state_e          state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [PtrW-1:0]     rr_q, rr_d;
  logic [N_ST-1:0]     elig;
  logic                slot_free;
  logic [PtrW-1:0]     pick_idx;
  logic                pick_any;
  logic [DATA_W-1:0]   res [N_ST];

  assign CDB_Valid   = (state_q == StBcast);
  assign Qi_CDB      = tag_q;
  assign Qi_CDB_data = data_q;

  always_comb begin
    Ack = '0;
    for (int i = 0; i < N_ST; i++) begin
      Ack[i] = CDB_Valid && !Stall && (tag_q == TAG_W'(i + 1));
      res[i] = Result[i*DATA_W +: DATA_W];
    end
  end

  // A station being acked this cycle must drop Ready before it can win again.
  assign elig      = Ready & ~Ack;
  assign slot_free = !CDB_Valid || !Stall;

  rr_picker #(
    .N    (N_ST),
    .PtrW (PtrW)
  ) u_rr_picker (
    .elig_i (elig),
    .ptr_i  (rr_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    data_d  = data_q;
    rr_d    = rr_q;
    if (slot_free) begin
      if (pick_any) begin
        state_d = StBcast;
        tag_d   = TAG_W'(pick_idx) + TAG_W'(1);
        data_d  = res[pick_idx];
        rr_d    = (pick_idx == PtrW'(N_ST - 1)) ? '0 : pick_idx + PtrW'(1);
      end else begin
        state_d = StIdle;
        tag_d   = TAG_W'(FREE_REGISTER);
        data_d  = DATA_W'(sem_valor);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= StIdle;
      tag_q   <= TAG_W'(FREE_REGISTER);
      data_q  <= DATA_W'(sem_valor);
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
    end
  end

`ifdef CDB_STATS_EN
  logic [15:0] bcast_q, bcast_d;
  logic [15:0] conf_q, conf_d;
  logic        multi_elig;

  always_comb begin
    multi_elig = |(elig & (elig - N_ST'(1)));
    bcast_d    = bcast_q;
    conf_d     = conf_q;
    if (CDB_Valid && !Stall && (bcast_q != 16'hFFFF)) begin
      bcast_d = bcast_q + 16'd1;
    end
    if ((multi_elig || ((|elig) && !slot_free)) && (conf_q != 16'hFFFF)) begin
      conf_d = conf_q + 16'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      bcast_q <= '0;
      conf_q  <= '0;
    end else begin
      bcast_q <= bcast_d;
      conf_q  <= conf_d;
    end
  end

  assign Bcast_Count    = bcast_q;
  assign Conflict_Count = conf_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with N_ST=2; counter checks are built when CDB_STATS_EN is defined.
module tb_cdb_arbiter;

  logic        Clock;
  logic        Reset;
  logic [1:0]  Ready;
  logic [31:0] Result;
  logic        Stall;
  logic [1:0]  Ack;
  logic        CDB_Valid;
  logic [2:0]  Qi_CDB;
  logic [15:0] Qi_CDB_data;
`ifdef CDB_STATS_EN
  logic [15:0] Bcast_Count;
  logic [15:0] Conflict_Count;
`endif

  int vectors;
  int errors;

  cdb_arbiter #(
    .N_ST   (2),
    .DATA_W (16),
    .TAG_W  (3)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Ready       (Ready),
    .Result      (Result),
    .Stall       (Stall),
    .Ack         (Ack),
    .CDB_Valid   (CDB_Valid),
    .Qi_CDB      (Qi_CDB),
    .Qi_CDB_data (Qi_CDB_data)
`ifdef CDB_STATS_EN
    ,
    .Bcast_Count    (Bcast_Count),
    .Conflict_Count (Conflict_Count)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Ready = 2'b00;
    Stall = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Result = 32'h0;
    do_reset();
    tick();
    vectors++;
    if (CDB_Valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", CDB_Valid);
    end
    vectors++;
    if (Qi_CDB !== 3'd0) begin
      errors++; $display("FAIL reset_tag got %0d want 0", Qi_CDB);
    end
    vectors++;
    if (Qi_CDB_data !== 16'hFFF0) begin
      errors++; $display("FAIL reset_data got %h want fff0", Qi_CDB_data);
    end
    vectors++;
    if (Ack !== 2'b00) begin
      errors++; $display("FAIL reset_ack got %b want 00", Ack);
    end
  endtask

  task automatic test_single();
    do_reset();
    Ready  = 2'b01;
    Result = {16'h0000, 16'h0005};
    tick();
    vectors++;
    if ({CDB_Valid, Qi_CDB, Qi_CDB_data, Ack} !== {1'b1, 3'd1, 16'h0005, 2'b01}) begin
      errors++; $display("FAIL single_bcast got v=%b tag=%0d data=%h ack=%b want v=1 tag=1 data=0005 ack=01",
                         CDB_Valid, Qi_CDB, Qi_CDB_data, Ack);
    end
    tick();
    Ready = 2'b00;
    vectors++;
    if ({CDB_Valid, Qi_CDB, Qi_CDB_data, Ack} !== {1'b0, 3'd0, 16'hFFF0, 2'b00}) begin
      errors++; $display("FAIL single_idle got v=%b tag=%0d data=%h ack=%b want v=0 tag=0 data=fff0 ack=00",
                         CDB_Valid, Qi_CDB, Qi_CDB_data, Ack);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    Ready  = 2'b11;
    Result = {16'h0022, 16'h0011};
    tick();
    vectors++;
    if ({Qi_CDB, Qi_CDB_data, Ack} !== {3'd1, 16'h0011, 2'b01}) begin
      errors++; $display("FAIL b2b_first got tag=%0d data=%h ack=%b want tag=1 data=0011 ack=01",
                         Qi_CDB, Qi_CDB_data, Ack);
    end
    tick();
    Ready = 2'b10;
    vectors++;
    if ({CDB_Valid, Qi_CDB, Qi_CDB_data, Ack} !== {1'b1, 3'd2, 16'h0022, 2'b10}) begin
      errors++; $display("FAIL b2b_second got v=%b tag=%0d data=%h ack=%b want v=1 tag=2 data=0022 ack=10",
                         CDB_Valid, Qi_CDB, Qi_CDB_data, Ack);
    end
    tick();
    Ready = 2'b00;
    vectors++;
    if (CDB_Valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got v=%b want 0", CDB_Valid);
    end
    // Pointer wrapped back to 0, so station 0 wins the next contention.
    Ready  = 2'b11;
    Result = {16'h0055, 16'h0044};
    tick();
    vectors++;
    if ({Qi_CDB, Qi_CDB_data, Ack} !== {3'd1, 16'h0044, 2'b01}) begin
      errors++; $display("FAIL rr_wrap got tag=%0d data=%h ack=%b want tag=1 data=0044 ack=01",
                         Qi_CDB, Qi_CDB_data, Ack);
    end
    tick();
    Ready = 2'b10;
    vectors++;
    if ({Qi_CDB, Qi_CDB_data} !== {3'd2, 16'h0055}) begin
      errors++; $display("FAIL rr_wrap_second got tag=%0d data=%h want tag=2 data=0055",
                         Qi_CDB, Qi_CDB_data);
    end
    tick();
    Ready = 2'b00;
  endtask

  task automatic test_stall();
    do_reset();
    Stall  = 1'b1;
    Ready  = 2'b10;
    Result = {16'h0033, 16'h0000};
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if ({CDB_Valid, Qi_CDB, Qi_CDB_data, Ack} !== {1'b1, 3'd2, 16'h0033, 2'b00}) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b tag=%0d data=%h ack=%b want v=1 tag=2 data=0033 ack=00",
                           c, CDB_Valid, Qi_CDB, Qi_CDB_data, Ack);
      end
    end
    Stall = 1'b0;
    #1;
    vectors++;
    if ({Qi_CDB_data, Ack} !== {16'h0033, 2'b10}) begin
      errors++; $display("FAIL stall_release got data=%h ack=%b want data=0033 ack=10",
                         Qi_CDB_data, Ack);
    end
    tick();
    Ready = 2'b00;
    vectors++;
    if ({CDB_Valid, Qi_CDB} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL stall_idle got v=%b tag=%0d want v=0 tag=0", CDB_Valid, Qi_CDB);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    Stall  = 1'b1;
    Ready  = 2'b01;
    Result = {16'h0000, 16'h0077};
    tick();
    vectors++;
    if ({CDB_Valid, Qi_CDB} !== {1'b1, 3'd1}) begin
      errors++; $display("FAIL midrst_pre got v=%b tag=%0d want v=1 tag=1", CDB_Valid, Qi_CDB);
    end
    Reset = 1'b0;
    tick();
    vectors++;
    if ({CDB_Valid, Qi_CDB, Qi_CDB_data, Ack} !== {1'b0, 3'd0, 16'hFFF0, 2'b00}) begin
      errors++; $display("FAIL midrst_idle got v=%b tag=%0d data=%h ack=%b want v=0 tag=0 data=fff0 ack=00",
                         CDB_Valid, Qi_CDB, Qi_CDB_data, Ack);
    end
    Reset = 1'b1;
    Stall = 1'b0;
    tick();
    vectors++;
    if ({CDB_Valid, Qi_CDB, Qi_CDB_data, Ack} !== {1'b1, 3'd1, 16'h0077, 2'b01}) begin
      errors++; $display("FAIL midrst_regrant got v=%b tag=%0d data=%h ack=%b want v=1 tag=1 data=0077 ack=01",
                         CDB_Valid, Qi_CDB, Qi_CDB_data, Ack);
    end
    tick();
    Ready = 2'b00;
  endtask

`ifdef CDB_STATS_EN
  task automatic test_stats();
    do_reset();
    Ready  = 2'b01;
    Result = {16'h0002, 16'h0001};
    tick();
    tick();
    Ready = 2'b11;
    tick();
    tick();
    Ready = 2'b10;
    tick();
    Ready = 2'b10;
    tick();
    tick();
    Ready = 2'b00;
    tick();
    vectors++;
    if (Bcast_Count !== 16'd4) begin
      errors++; $display("FAIL stats_bcast got %0d want 4", Bcast_Count);
    end
    vectors++;
    if (Conflict_Count !== 16'd1) begin
      errors++; $display("FAIL stats_conflict got %0d want 1", Conflict_Count);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    errors  = 0;
    Reset   = 1'b0;
    Ready   = 2'b00;
    Stall   = 1'b0;
    Result  = 32'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef CDB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus (CDB) arbiter and broadcaster for the Tomasulo core. Reservation stations raise `Ready` with a finished `Result`. This block picks one station per cycle in round-robin order, registers that station's tag and value, and drives them onto the CDB (`Qi_CDB`, `Qi_CDB_data`) to `register_status` and all stations. It then returns a one-cycle `Ack` so the winning station can free itself.

## Interface
- `N_ST`, default 2: number of reservation stations. Range 2..7. Station i has tag i+1.
- `DATA_W`, default 16: result width.
- `TAG_W`, default 3: tag width. Tag 0 = `FREE_REGISTER` (no producer).
- `Clock` in, 1: sole clock, rising edge.
- `Reset` in, 1: synchronous, active-low.
- `Ready` in, N_ST: per-station result-valid. Stays high until that station's `Ack` is seen.
- `Result` in, N_ST*DATA_W: station i's result in bits [i*DATA_W +: DATA_W]. Stable while `Ready[i]` is high.
- `Stall` in, 1: consumer cannot accept the broadcast this cycle.
- `Ack` out, N_ST: one-hot pulse to the station whose broadcast is accepted this cycle.
- `CDB_Valid` out, 1: a broadcast is on the bus.
- `Qi_CDB` out, TAG_W: producing-station tag. 0 when idle.
- `Qi_CDB_data` out, DATA_W: broadcast value. `sem_valor` (16'hFFF0) when idle.

## Operation
- FSM has two states:
  - `IDLE`: `CDB_Valid`=0.
  - `BCAST`: `CDB_Valid`=1, output registers hold tag and data.
- Output slot is free at the next edge when `!CDB_Valid || !Stall`.
- Eligible set = `Ready & ~Ack`. A station being acked this cycle cannot be regranted until it re-raises `Ready`.
- Grant at an edge: if the slot is free and the eligible set is non-empty:
  - Search from `rr_ptr` upward with wrap, pick the first eligible index i.
  - Load `Qi_CDB`=i+1 and `Qi_CDB_data`=`Result[i]`, and go to `BCAST`.
  - Set `rr_ptr`=(i+1) mod N_ST.
- Slot free and nothing eligible: go to `IDLE`. Tag returns to 0 and data to `sem_valor`.
- Slot not free (`BCAST` with `Stall`=1): hold all outputs and `rr_ptr`. No grant.
- `Ack[i]` = `CDB_Valid && !Stall && (Qi_CDB == i+1)`. This is combinational from registered state and `Stall`. It is never asserted in `IDLE`.
- Back-to-back grants to different stations are allowed, one per cycle.
- `Ready` dropping before its `Ack` is a station protocol violation. The arbiter still completes any broadcast already registered.
- Reset (`Reset`=0 at an edge) has priority over everything, including mid-broadcast:
  - State `IDLE`, `rr_ptr`=0, `CDB_Valid`=0, `Qi_CDB`=0, `Qi_CDB_data`=16'hFFF0, `Ack`=0.
  - Statistics counters (when `CDB_STATS_EN` is defined) = 0.
  - A pending broadcast is discarded. Its station remains `Ready` and is regranted after reset.

## Timing
- Latency: `Ready[i]` high at edge k with a free slot → `CDB_Valid`/`Qi_CDB` valid from k to k+1 → `Ack[i]` high in that same cycle if `Stall`=0.
- Station clears `Ready` at the edge where it samples `Ack`=1.
- Sustained throughput: one broadcast per cycle with `Stall`=0.
- A `Stall` run of S cycles delays `Ack` by S cycles. The data stays stable throughout.
- With all N_ST stations requesting continuously, each station wins at least once every N_ST grants.

## Configuration
- `CDB_STATS_EN` defined:
  - Adds output `Bcast_Count` (16 bits): +1 per accepted broadcast (`CDB_Valid && !Stall`).
  - Adds output `Conflict_Count` (16 bits): +1 per edge where more than one station is eligible, or where a station is eligible while the slot is blocked.
  - Both counters saturate at 16'hFFFF.
- `CDB_STATS_EN` not defined: neither port nor any counter logic exists. Functional behaviour is identical.

## Structure
- Shared package `tomasulo_pkg`:
  - Tag constants `FREE_REGISTER`=0, `RES_STATION_ADD1`=1, `RES_STATION_ADD2`=2.
  - `sem_valor`=16'hFFF0.
  - `DATA_W` and `TAG_W` defaults.
  - FSM state encoding.
- One sub-module, `rr_picker`: combinational round-robin priority search. Inputs: eligible vector, `rr_ptr`. Outputs: grant index, `any` flag.
- `cdb_arbiter` owns the FSM, output registers, `rr_ptr` and optional counters.
- In the core top it replaces the direct `Qi_CDB`/`Qi_CDB_data` nets.

## Test plan
- Idle after reset: `Reset`=0 for 2 cycles, then 1 → `CDB_Valid`=0, `Qi_CDB`=0, `Qi_CDB_data`=16'hFFF0, `Ack`=0.
- Single request: `Ready`=01, `Result[0]`=16'h0005 → next cycle `Qi_CDB`=1, data 16'h0005, `Ack`=01. `Ready` drops and the bus returns to idle.
- Simultaneous requests: `Ready`=11, results 16'h0011 and 16'h0022, `rr_ptr`=0 → tag 1 / 16'h0011, then tag 2 / 16'h0022 on consecutive cycles. The next contention is won by station 0 (`rr_ptr`=0).
- Stall: broadcast of tag 2, 16'h0033 with `Stall`=1 for 3 cycles → outputs stable and `Ack`=00 for 3 cycles. `Ack`=10 in the cycle `Stall` falls.
- Reset mid-broadcast: `Reset`=0 while `CDB_Valid`=1 → idle values at the next edge. After release, the still-`Ready` station is rebroadcast with the same data.
- With `CDB_STATS_EN`: 4 accepted broadcasts including one `Ready`=11 collision → `Bcast_Count`=4, `Conflict_Count`=1.
